// File: rtl/tl_pkg.sv
// Shared TileLink types: channel opcodes, fixed bus widths and per-channel payload structs.
// Blocks that speak TL import this package rather than declaring their own channel types.
package tl_pkg;

    localparam int TL_DW    = 64;
    localparam int TL_AW    = 56;
    localparam int TL_SRCW  = 1;
    localparam int TL_SINKW = 1;
    localparam int TL_DBW   = TL_DW / 8;

    typedef enum logic [2:0] {
        PutFullData    = 3'd0,
        PutPartialData = 3'd1,
        ArithmeticData = 3'd2,
        LogicalData    = 3'd3,
        Get            = 3'd4,
        Intent         = 3'd5,
        AcquireBlock   = 3'd6,
        AcquirePerm    = 3'd7
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'd0,
        AccessAckData = 3'd1,
        HintAck       = 3'd2,
        Grant         = 3'd4,
        GrantData     = 3'd5,
        ReleaseAck    = 3'd6
    } tl_d_op_e;

    typedef struct packed {
        tl_a_op_e            opcode;
        logic [2:0]          param;
        logic [2:0]          size;
        logic [TL_SRCW-1:0]  source;
        logic [TL_AW-1:0]    address;
        logic [TL_DBW-1:0]   mask;
        logic [TL_DW-1:0]    data;
        logic                corrupt;
    } tl_a_t;

    typedef struct packed {
        logic [2:0]          opcode;
        logic [1:0]          param;
        logic [2:0]          size;
        logic [TL_SRCW-1:0]  source;
        logic [TL_AW-1:0]    address;
        logic [TL_DBW-1:0]   mask;
        logic [TL_DW-1:0]    data;
        logic                corrupt;
    } tl_b_t;

    typedef struct packed {
        logic [2:0]          opcode;
        logic [2:0]          param;
        logic [2:0]          size;
        logic [TL_SRCW-1:0]  source;
        logic [TL_AW-1:0]    address;
        logic [TL_DW-1:0]    data;
        logic                corrupt;
    } tl_c_t;

    typedef struct packed {
        tl_d_op_e            opcode;
        logic [1:0]          param;
        logic [2:0]          size;
        logic [TL_SRCW-1:0]  source;
        logic [TL_SINKW-1:0] sink;
        logic                denied;
        logic [TL_DW-1:0]    data;
        logic                corrupt;
    } tl_d_t;

    typedef struct packed {
        logic [TL_SINKW-1:0] sink;
    } tl_e_t;

endpackage

// File: rtl/tl_bram_host_adapter.sv
// Bridges a simple BRAM-style word request port onto a TileLink host port, one transaction at a time.
// Optional TL_BRAM_HOST_ADAPTER_ERR_EN adds rsp_err_o (d_denied | d_corrupt) alongside the response pulse.
module tl_bram_host_adapter
    import tl_pkg::*;
#(
    parameter int DataWidth     = 64,
    parameter int AddrWidth     = 56,
    parameter int SourceWidth   = 1,
    parameter int SinkWidth     = 1,
    parameter int BramAddrWidth = 53
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic                     req_we_i,
    input  logic [BramAddrWidth-1:0] req_addr_i,
    input  logic [DataWidth/8-1:0]   req_wmask_i,
    input  logic [DataWidth-1:0]     req_wdata_i,
    output logic                     rsp_valid_o,
    output logic [DataWidth-1:0]     rsp_rdata_o,
`ifdef TL_BRAM_HOST_ADAPTER_ERR_EN
    output logic                     rsp_err_o,
`endif
    output logic                     device_a_valid_o,
    input  logic                     device_a_ready_i,
    output tl_a_t                    device_a_o,
    input  logic                     device_b_valid_i,
    output logic                     device_b_ready_o,
    input  tl_b_t                    device_b_i,
    output logic                     device_c_valid_o,
    input  logic                     device_c_ready_i,
    output tl_c_t                    device_c_o,
    input  logic                     device_d_valid_i,
    output logic                     device_d_ready_o,
    input  tl_d_t                    device_d_i,
    output logic                     device_e_valid_o,
    input  logic                     device_e_ready_i,
    output tl_e_t                    device_e_o
);

    // The channel structs are sized by the shared package, so the parameters must agree with it.
    if ((DataWidth != TL_DW) || (AddrWidth != TL_AW) || (SourceWidth != TL_SRCW) ||
        (SinkWidth != TL_SINKW) || (BramAddrWidth + 3 > AddrWidth)) begin : g_param_err
        $error("tl_bram_host_adapter: unsupported parameter combination");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic                     we_q, we_d;
    logic [BramAddrWidth-1:0] addr_q, addr_d;
    logic [DataWidth/8-1:0]   wmask_q, wmask_d;
    logic [DataWidth-1:0]     wdata_q, wdata_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic [DataWidth-1:0]     rsp_rdata_q, rsp_rdata_d;

    always_comb begin
        state_d          = state_q;
        we_d             = we_q;
        addr_d           = addr_q;
        wmask_d          = wmask_q;
        wdata_d          = wdata_q;
        rsp_valid_d      = 1'b0;
        rsp_rdata_d      = rsp_rdata_q;
        req_ready_o      = 1'b0;
        device_a_valid_o = 1'b0;
        device_d_ready_o = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    addr_d  = req_addr_i;
                    wmask_d = req_wmask_i;
                    wdata_d = req_wdata_i;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                device_a_valid_o = 1'b1;
                if (device_a_ready_i) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                device_d_ready_o = 1'b1;
                if (device_d_valid_i) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = device_d_i.data;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A fields come only from captured registers, so they stay stable while a_ready is low.
    always_comb begin
        device_a_o         = '0;
        device_a_o.size    = 3'd3;
        device_a_o.address[BramAddrWidth+2:0] = {addr_q, 3'b000};
        device_a_o.data    = wdata_q;
        if (!we_q) begin
            device_a_o.opcode = Get;
            device_a_o.mask   = '1;
        end else begin
            device_a_o.opcode = (wmask_q == '1) ? PutFullData : PutPartialData;
            device_a_o.mask   = wmask_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wmask_q     <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wmask_q     <= wmask_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign rsp_valid_o      = rsp_valid_q;
    assign rsp_rdata_o      = rsp_rdata_q;
    assign device_b_ready_o = 1'b1;
    assign device_c_valid_o = 1'b0;
    assign device_c_o       = '0;
    assign device_e_valid_o = 1'b0;
    assign device_e_o       = '0;

`ifdef TL_BRAM_HOST_ADAPTER_ERR_EN
    logic rsp_err_q, rsp_err_d;

    always_comb begin
        rsp_err_d = 1'b0;
        if (state_q == ST_WAIT && device_d_valid_i) begin
            rsp_err_d = device_d_i.denied | device_d_i.corrupt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) rsp_err_q <= 1'b0;
        else         rsp_err_q <= rsp_err_d;
    end

    assign rsp_err_o = rsp_err_q;
`else
    logic unused_d_err;
    assign unused_d_err = device_d_i.denied ^ device_d_i.corrupt;
`endif

    logic unused_tl;
    assign unused_tl = ^{device_b_valid_i, device_b_i, device_c_ready_i, device_e_ready_i,
                         device_d_i.opcode, device_d_i.param, device_d_i.size,
                         device_d_i.source, device_d_i.sink};

endmodule

// File: tb/tb_tl_bram_host_adapter.sv
// Directed bench for tl_bram_host_adapter: reads, full/partial writes, back-pressure and reset abort.
module tb_tl_bram_host_adapter;
    import tl_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i, req_ready_o, req_we_i;
    logic [52:0] req_addr_i;
    logic [7:0]  req_wmask_i;
    logic [63:0] req_wdata_i;
    logic        rsp_valid_o;
    logic [63:0] rsp_rdata_o;
`ifdef TL_BRAM_HOST_ADAPTER_ERR_EN
    logic        rsp_err_o;
`endif
    logic        a_valid, a_ready, b_valid, b_ready, c_valid, c_ready;
    logic        d_valid, d_ready, e_valid, e_ready;
    tl_a_t       a_o;
    tl_b_t       b_i;
    tl_c_t       c_o;
    tl_d_t       d_i;
    tl_e_t       e_o;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk_i = ~clk_i;

    tl_bram_host_adapter dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_we_i         (req_we_i),
        .req_addr_i       (req_addr_i),
        .req_wmask_i      (req_wmask_i),
        .req_wdata_i      (req_wdata_i),
        .rsp_valid_o      (rsp_valid_o),
        .rsp_rdata_o      (rsp_rdata_o),
`ifdef TL_BRAM_HOST_ADAPTER_ERR_EN
        .rsp_err_o        (rsp_err_o),
`endif
        .device_a_valid_o (a_valid),
        .device_a_ready_i (a_ready),
        .device_a_o       (a_o),
        .device_b_valid_i (b_valid),
        .device_b_ready_o (b_ready),
        .device_b_i       (b_i),
        .device_c_valid_o (c_valid),
        .device_c_ready_i (c_ready),
        .device_c_o       (c_o),
        .device_d_valid_i (d_valid),
        .device_d_ready_o (d_ready),
        .device_d_i       (d_i),
        .device_e_valid_o (e_valid),
        .device_e_ready_i (e_ready),
        .device_e_o       (e_o)
    );

    // One complete transaction; entered and left at a falling edge with the DUT idle.
    task automatic run_txn(input logic we, input logic [52:0] addr, input logic [7:0] mask,
                           input logic [63:0] wdata, input tl_a_op_e exp_op,
                           input logic [7:0] exp_mask, input int a_wait, input int d_wait,
                           input logic [63:0] ddata, input logic denied);
        tl_a_t exp_a;
        exp_a         = '0;
        exp_a.opcode  = exp_op;
        exp_a.size    = 3'd3;
        exp_a.address = {3'b000, addr, 3'b000};
        exp_a.mask    = exp_mask;
        exp_a.data    = wdata;
        req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr;
        req_wmask_i = mask; req_wdata_i = wdata;
        #1;
        n_chk++;
        if (req_ready_o === 1'b1) n_pass++;
        else $error("FAIL idle_req_ready: observed %0h expected %0h", req_ready_o, 1'b1);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        for (int i = 0; i < a_wait; i++) begin
            #1;
            n_chk++;
            if (a_valid === 1'b1) n_pass++;
            else $error("FAIL stall_a_valid: observed %0h expected %0h", a_valid, 1'b1);
            n_chk++;
            if (a_o === exp_a) n_pass++;
            else $error("FAIL stall_a_fields: observed %0h expected %0h", a_o, exp_a);
            n_chk++;
            if (req_ready_o === 1'b0) n_pass++;
            else $error("FAIL stall_req_ready: observed %0h expected %0h", req_ready_o, 1'b0);
            @(negedge clk_i);
        end
        #1;
        n_chk++;
        if (a_valid === 1'b1) n_pass++;
        else $error("FAIL issue_a_valid: observed %0h expected %0h", a_valid, 1'b1);
        n_chk++;
        if (a_o === exp_a) n_pass++;
        else $error("FAIL issue_a_fields: observed %0h expected %0h", a_o, exp_a);
        n_chk++;
        if (d_ready === 1'b0) n_pass++;
        else $error("FAIL issue_d_ready: observed %0h expected %0h", d_ready, 1'b0);
        a_ready = 1'b1;
        @(negedge clk_i);
        a_ready = 1'b0;
        for (int i = 0; i < d_wait; i++) begin
            #1;
            n_chk++;
            if (d_ready === 1'b1) n_pass++;
            else $error("FAIL wait_d_ready: observed %0h expected %0h", d_ready, 1'b1);
            n_chk++;
            if (rsp_valid_o === 1'b0) n_pass++;
            else $error("FAIL wait_no_rsp: observed %0h expected %0h", rsp_valid_o, 1'b0);
            n_chk++;
            if (req_ready_o === 1'b0) n_pass++;
            else $error("FAIL wait_req_ready: observed %0h expected %0h", req_ready_o, 1'b0);
            @(negedge clk_i);
        end
        #1;
        n_chk++;
        if (a_valid === 1'b0) n_pass++;
        else $error("FAIL wait_a_valid: observed %0h expected %0h", a_valid, 1'b0);
        n_chk++;
        if (d_ready === 1'b1) n_pass++;
        else $error("FAIL wait_d_ready: observed %0h expected %0h", d_ready, 1'b1);
        d_valid = 1'b1;
        d_i = '0;
        d_i.opcode = we ? AccessAck : AccessAckData;
        d_i.data   = ddata;
        d_i.denied = denied;
        @(negedge clk_i);
        d_valid = 1'b0;
        d_i.data = 64'h0;
        #1;
        n_chk++;
        if (rsp_valid_o === 1'b1) n_pass++;
        else $error("FAIL rsp_pulse: observed %0h expected %0h", rsp_valid_o, 1'b1);
        n_chk++;
        if (req_ready_o === 1'b1) n_pass++;
        else $error("FAIL rsp_req_ready: observed %0h expected %0h", req_ready_o, 1'b1);
        if (!we) begin
            n_chk++;
            if (rsp_rdata_o === ddata) n_pass++;
            else $error("FAIL rsp_rdata: observed %0h expected %0h", rsp_rdata_o, ddata);
        end
`ifdef TL_BRAM_HOST_ADAPTER_ERR_EN
        n_chk++;
        if (rsp_err_o === denied) n_pass++;
        else $error("FAIL rsp_err_pulse: observed %0h expected %0h", rsp_err_o, denied);
`endif
        @(negedge clk_i);
        #1;
        n_chk++;
        if (rsp_valid_o === 1'b0) n_pass++;
        else $error("FAIL rsp_pulse_end: observed %0h expected %0h", rsp_valid_o, 1'b0);
        if (!we) begin
            n_chk++;
            if (rsp_rdata_o === ddata) n_pass++;
            else $error("FAIL rsp_rdata_hold: observed %0h expected %0h", rsp_rdata_o, ddata);
        end
`ifdef TL_BRAM_HOST_ADAPTER_ERR_EN
        n_chk++;
        if (rsp_err_o === 1'b0) n_pass++;
        else $error("FAIL rsp_err_clear: observed %0h expected %0h", rsp_err_o, 1'b0);
`endif
        d_i.denied = 1'b0;
        @(negedge clk_i);
    endtask

    initial begin
        rst_ni = 1'b0;
        req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0; req_wmask_i = '0; req_wdata_i = '0;
        a_ready = 1'b0; b_valid = 1'b0; b_i = '0; c_ready = 1'b0;
        d_valid = 1'b0; d_i = '0; e_ready = 1'b0;
        repeat (2) @(negedge clk_i);
        #1;
        n_chk++;
        if (req_ready_o === 1'b1) n_pass++;
        else $error("FAIL rst_req_ready: observed %0h expected %0h", req_ready_o, 1'b1);
        n_chk++;
        if (a_valid === 1'b0) n_pass++;
        else $error("FAIL rst_a_valid: observed %0h expected %0h", a_valid, 1'b0);
        n_chk++;
        if (d_ready === 1'b0) n_pass++;
        else $error("FAIL rst_d_ready: observed %0h expected %0h", d_ready, 1'b0);
        n_chk++;
        if (rsp_valid_o === 1'b0) n_pass++;
        else $error("FAIL rst_rsp_valid: observed %0h expected %0h", rsp_valid_o, 1'b0);
        n_chk++;
        if (rsp_rdata_o === 64'h0) n_pass++;
        else $error("FAIL rst_rsp_rdata: observed %0h expected %0h", rsp_rdata_o, 64'h0);
        n_chk++;
        if (b_ready === 1'b1) n_pass++;
        else $error("FAIL tie_b_ready: observed %0h expected %0h", b_ready, 1'b1);
        n_chk++;
        if (c_valid === 1'b0) n_pass++;
        else $error("FAIL tie_c_valid: observed %0h expected %0h", c_valid, 1'b0);
        n_chk++;
        if (e_valid === 1'b0) n_pass++;
        else $error("FAIL tie_e_valid: observed %0h expected %0h", e_valid, 1'b0);
`ifdef TL_BRAM_HOST_ADAPTER_ERR_EN
        n_chk++;
        if (rsp_err_o === 1'b0) n_pass++;
        else $error("FAIL rst_rsp_err: observed %0h expected %0h", rsp_err_o, 1'b0);
`endif

        // Stray D beat while idle must be back-pressured and produce no response.
        @(negedge clk_i);
        rst_ni = 1'b1;
        d_valid = 1'b1;
        d_i.data = 64'h5555_5555_5555_5555;
        #1;
        n_chk++;
        if (d_ready === 1'b0) n_pass++;
        else $error("FAIL idle_d_ready: observed %0h expected %0h", d_ready, 1'b0);
        @(negedge clk_i);
        #1;
        n_chk++;
        if (rsp_valid_o === 1'b0) n_pass++;
        else $error("FAIL idle_no_rsp: observed %0h expected %0h", rsp_valid_o, 1'b0);
        n_chk++;
        if (rsp_rdata_o === 64'h0) n_pass++;
        else $error("FAIL idle_rdata_kept: observed %0h expected %0h", rsp_rdata_o, 64'h0);
        d_valid = 1'b0;
        d_i = '0;
        @(negedge clk_i);

        run_txn(1'b0, 53'h10, 8'h00, 64'h0, Get, 8'hFF, 0, 0, 64'hDEADBEEF_CAFEF00D, 1'b0);
        run_txn(1'b1, 53'h20, 8'hFF, 64'h1122334455667788, PutFullData, 8'hFF, 0, 0, 64'h0, 1'b0);
        run_txn(1'b1, 53'h3, 8'h0F, 64'hAAAA_BBBB_CCCC_DDDD, PutPartialData, 8'h0F, 1, 2, 64'h0, 1'b0);
        run_txn(1'b1, 53'h4, 8'h00, 64'h0F0F_0F0F_0F0F_0F0F, PutPartialData, 8'h00, 0, 0, 64'h0, 1'b0);
        run_txn(1'b0, 53'h1F_FFFF_FFFF_FFFF, 8'h00, 64'h0, Get, 8'hFF, 5, 7, 64'h0123456789ABCDEF, 1'b0);

        // Reset while waiting for D abandons the transaction without a response.
        req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 53'h5; req_wmask_i = 8'h00; req_wdata_i = '0;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        a_ready = 1'b1;
        @(negedge clk_i);
        a_ready = 1'b0;
        #1;
        n_chk++;
        if (d_ready === 1'b1) n_pass++;
        else $error("FAIL abort_in_wait: observed %0h expected %0h", d_ready, 1'b1);
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        n_chk++;
        if (req_ready_o === 1'b1) n_pass++;
        else $error("FAIL abort_req_ready: observed %0h expected %0h", req_ready_o, 1'b1);
        n_chk++;
        if (d_ready === 1'b0) n_pass++;
        else $error("FAIL abort_d_ready: observed %0h expected %0h", d_ready, 1'b0);
        n_chk++;
        if (a_valid === 1'b0) n_pass++;
        else $error("FAIL abort_a_valid: observed %0h expected %0h", a_valid, 1'b0);
        n_chk++;
        if (rsp_valid_o === 1'b0) n_pass++;
        else $error("FAIL abort_no_rsp: observed %0h expected %0h", rsp_valid_o, 1'b0);
        n_chk++;
        if (rsp_rdata_o === 64'h0) n_pass++;
        else $error("FAIL abort_rdata_clr: observed %0h expected %0h", rsp_rdata_o, 64'h0);
        @(negedge clk_i);
        #1;
        n_chk++;
        if (rsp_valid_o === 1'b0) n_pass++;
        else $error("FAIL abort_no_rsp_late: observed %0h expected %0h", rsp_valid_o, 1'b0);
        run_txn(1'b0, 53'h6, 8'h00, 64'h0, Get, 8'hFF, 0, 0, 64'h0BAD_F00D_1234_5678, 1'b0);

        // Denied response: only visible on rsp_err_o when the error port is built in.
        run_txn(1'b0, 53'h7, 8'h00, 64'h0, Get, 8'hFF, 0, 1, 64'h7777_8888_9999_AAAA, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "bench timeout");
    end

endmodule
